// File: rtl/mux_bs_demux.sv
// One-to-four demultiplexer: each channel has a one-entry output register,
// and bs selects the destination. Define MUX_BS_DEMUX_COUNT_EN to add the xfer_cnt port.
module mux_bs_demux #(
  parameter int n = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] in,
  input  logic         in_val,
  input  logic [1:0]   bs,
  output logic         in_rdy,
  output logic [n-1:0] out0,
  output logic [n-1:0] out1,
  output logic [n-1:0] out2,
  output logic [n-1:0] out3,
  output logic [3:0]   out_val,
  input  logic [3:0]   out_rdy
`ifdef MUX_BS_DEMUX_COUNT_EN
  ,
  output logic [31:0]  xfer_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

  chan_state_t  state_q [4];
  chan_state_t  state_d [4];
  logic [n-1:0] data_q  [4];
  logic [3:0]   load;
  logic [3:0]   drain;
  logic         xfer_in;

  always_comb begin
    out_val = '0;
    load    = '0;
    drain   = '0;
    for (int i = 0; i < 4; i++) begin
      out_val[i] = (state_q[i] == FULL);
    end
    // Ready is a function of the selected channel only, never of in_val.
    in_rdy  = !out_val[bs] | out_rdy[bs];
    xfer_in = in_val & in_rdy;
    for (int i = 0; i < 4; i++) begin
      load[i]    = xfer_in && (bs == i[1:0]);
      drain[i]   = out_val[i] & out_rdy[i];
      state_d[i] = state_q[i];
      case (state_q[i])
        EMPTY:   if (load[i]) state_d[i] = FULL;
        FULL:    if (drain[i] && !load[i]) state_d[i] = EMPTY;
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        if (load[i]) data_q[i] <= in;
      end
    end
  end

  assign out0 = data_q[0];
  assign out1 = data_q[1];
  assign out2 = data_q[2];
  assign out3 = data_q[3];

`ifdef MUX_BS_DEMUX_COUNT_EN
  logic [7:0] cnt_q [4];

  // Counters wrap naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drain[i]) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign xfer_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_mux_bs_demux.sv
// Directed bench for mux_bs_demux (8-bit payload); the counter check is
// compiled only with MUX_BS_DEMUX_COUNT_EN.
module tb_mux_bs_demux;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in;
  logic       in_val;
  logic [1:0] bs;
  logic       in_rdy;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] out_val;
  logic [3:0] out_rdy;
`ifdef MUX_BS_DEMUX_COUNT_EN
  logic [31:0] xfer_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mux_bs_demux #(.n(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .in_val  (in_val),
    .bs      (bs),
    .in_rdy  (in_rdy),
    .out0    (out0),
    .out1    (out1),
    .out2    (out2),
    .out3    (out3),
    .out_val (out_val),
    .out_rdy (out_rdy)
`ifdef MUX_BS_DEMUX_COUNT_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outsel(input int k);
    case (k)
      0:       return out0;
      1:       return out1;
      2:       return out2;
      default: return out3;
    endcase
  endfunction

  task automatic load_one(input logic [1:0] ch, input logic [7:0] v);
    bs = ch; in = v; in_val = 1'b1;
    tick();
    in_val = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in = '0; in_val = 1'b0; bs = '0; out_rdy = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_val", out_val, 4'b0000);
    chk("rst_outs", {out3, out2, out1, out0}, 32'h0);
    chk("rst_rdy", in_rdy, 1'b1);
`ifdef MUX_BS_DEMUX_COUNT_EN
    chk("rst_cnt", xfer_cnt, 32'h0);
`endif

    // Single load on channel 2
    bs = 2'd2; in = 8'hA5; in_val = 1'b1;
    #1 chk("a5_rdy", in_rdy, 1'b1);
    tick();
    in_val = 1'b0;
    chk("a5_out2", out2, 8'hA5);
    chk("a5_val", out_val, 4'b0100);
    chk("a5_others", {out3, out1, out0}, 24'h0);
    tick();
    chk("a5_hold_val", out_val, 4'b0100);
    out_rdy = 4'b0100;
    tick();
    out_rdy = 4'b0000;
    chk("a5_drained", out_val, 4'b0000);
    chk("a5_hold_data", out2, 8'hA5);

    // Backpressure on channel 1, with in changing while stalled
    load_one(2'd1, 8'h11);
    chk("bp_val", out_val, 4'b0010);
    bs = 2'd1; in = 8'h22; in_val = 1'b0;
    #1 chk("bp_rdy_noval", in_rdy, 1'b0);
    in_val = 1'b1;
    #1 chk("bp_rdy", in_rdy, 1'b0);
    tick();
    chk("bp_out1_held", out1, 8'h11);
    in = 8'h33; out_rdy = 4'b0010;
    #1 chk("bp_rdy_up", in_rdy, 1'b1);
    tick();
    in_val = 1'b0; out_rdy = 4'b0000;
    chk("bp_out1_new", out1, 8'h33);
    chk("bp_val_stay", out_val, 4'b0010);
    out_rdy = 4'b0010;
    tick();
    out_rdy = 4'b0000;
    chk("bp_drained", out_val, 4'b0000);

    // Round-robin stream with all consumers ready
    out_rdy = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      bs = k[1:0]; in = 8'h40 + k[7:0]; in_val = 1'b1;
      #1 chk("rr_rdy", in_rdy, 1'b1);
      tick();
      chk("rr_val", out_val, 4'b0001 << k);
      chk("rr_data", outsel(k), 8'h40 + k[7:0]);
    end
    in_val = 1'b0;
    tick();
    chk("rr_empty", out_val, 4'b0000);

    // Same-channel streaming: load and drain coincide
    for (int k = 0; k < 3; k++) begin
      bs = 2'd0; in = 8'h50 + k[7:0]; in_val = 1'b1;
      #1 chk("ft_rdy", in_rdy, 1'b1);
      tick();
      chk("ft_val", out_val, 4'b0001);
      chk("ft_data", out0, 8'h50 + k[7:0]);
    end
    in_val = 1'b0;
    tick();
    out_rdy = 4'b0000;
    chk("ft_empty", out_val, 4'b0000);

    // Independent draining: ch3 drains while ch0 stays blocked
    load_one(2'd0, 8'h60);
    load_one(2'd3, 8'h63);
    chk("ind_val", out_val, 4'b1001);
    out_rdy = 4'b1000; bs = 2'd0; in = 8'h61; in_val = 1'b1;
    #1 chk("ind_rdy", in_rdy, 1'b0);
    tick();
    in_val = 1'b0; out_rdy = 4'b0000;
    chk("ind_val2", out_val, 4'b0001);
    chk("ind_out0", out0, 8'h60);

    // Reset with everything full and a pending input
    for (int k = 1; k < 4; k++) load_one(k[1:0], 8'h70 + k[7:0]);
    chk("full_val", out_val, 4'b1111);
    reset = 1'b1; in_val = 1'b1; bs = 2'd0; in = 8'hAA; out_rdy = 4'b1111;
    tick();
    chk("rs_val", out_val, 4'b0000);
    chk("rs_outs", {out3, out2, out1, out0}, 32'h0);
    chk("rs_rdy", in_rdy, 1'b1);
    reset = 1'b0; in_val = 1'b0; out_rdy = 4'b0000;
    tick();
    chk("rs_noload", out_val, 4'b0000);

`ifdef MUX_BS_DEMUX_COUNT_EN
    // 257 transfers on channel 3 wrap its counter to 1
    out_rdy = 4'b1000; bs = 2'd3; in_val = 1'b1;
    for (int k = 0; k < 257; k++) begin
      in = k[7:0];
      tick();
    end
    in_val = 1'b0;
    tick();
    out_rdy = 4'b0000;
    chk("cnt_wrap", xfer_cnt, 32'h0100_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
